// File: rtl/paillier_pkg.sv
// Shared definitions for the Paillier operand path: default FIFO word width
// and the packer's two-state encoding.
package paillier_pkg;

  localparam int unsigned DEFAULT_WORD_WIDTH = 16;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/fifo_word_packer.sv
// Pops NUM_WORDS words from a FWFT FIFO and presents them as one wide operand
// over valid/ready. Define PACKER_MSW_FIRST_EN for big-endian slot order.
module fifo_word_packer
  import paillier_pkg::*;
#(
  parameter int unsigned WORD_WIDTH    = DEFAULT_WORD_WIDTH,
  parameter int unsigned NUM_WORDS     = 8,
  parameter int unsigned OPERAND_WIDTH = WORD_WIDTH * NUM_WORDS,
  parameter int unsigned CNT_WIDTH     = $clog2(NUM_WORDS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fifo_nempty,
  input  logic [WORD_WIDTH-1:0]    fifo_rd_data,
  output logic                     fifo_rd_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPERAND_WIDTH-1:0] out_data,
  output logic                     busy
);

  localparam logic [CNT_WIDTH-1:0] LAST_SLOT = CNT_WIDTH'(NUM_WORDS - 1);

  state_t                   state_q, state_d;
  logic [CNT_WIDTH-1:0]     cnt_q;
  logic [CNT_WIDTH-1:0]     slot_idx;
  logic [OPERAND_WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_COLLECT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT: if (fifo_rd_en && (cnt_q == LAST_SLOT)) state_d = ST_HOLD;
      ST_HOLD:    if (out_ready) state_d = ST_COLLECT;
      default:    state_d = ST_COLLECT;
    endcase
  end

  always_comb begin
    fifo_rd_en = ~rst & (state_q == ST_COLLECT) & fifo_nempty;
    out_valid  = (state_q == ST_HOLD);
    busy       = (cnt_q != '0) | (state_q == ST_HOLD);
  end

`ifdef PACKER_MSW_FIRST_EN
  always_comb slot_idx = LAST_SLOT - cnt_q;
`else
  always_comb slot_idx = cnt_q;
`endif

  // Slots not yet rewritten keep the previous operand; only out_valid qualifies them.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      data_q <= '0;
    end else if (fifo_rd_en) begin
      data_q[slot_idx*WORD_WIDTH +: WORD_WIDTH] <= fifo_rd_data;
      cnt_q <= (cnt_q == LAST_SLOT) ? '0 : cnt_q + CNT_WIDTH'(1);
    end
  end

  assign out_data = data_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer (WORD_WIDTH=16, NUM_WORDS=4) behind a depth-8 FWFT
// FIFO model; honours PACKER_MSW_FIRST_EN when selecting expected operands.
module tb_fifo_word_packer;

  localparam int W     = 16;
  localparam int N     = 4;
  localparam int OPW   = W * N;
  localparam int DEPTH = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           fifo_nempty;
  logic [W-1:0]   fifo_rd_data;
  logic           fifo_rd_en;
  logic           out_valid;
  logic           out_ready;
  logic [OPW-1:0] out_data;
  logic           busy;

  always #5 clk = ~clk;

  fifo_word_packer #(.WORD_WIDTH(W), .NUM_WORDS(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_nempty  (fifo_nempty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .busy         (busy)
  );

  // FWFT FIFO model shared with the packer's reset.
  logic [W-1:0] mem [DEPTH];
  int           rd_ptr, wr_ptr, count;
  logic         push;
  logic [W-1:0] push_data;

  always @(posedge clk) begin
    if (rst) begin
      rd_ptr <= 0;
      wr_ptr <= 0;
      count  <= 0;
    end else begin
      if (push && count < DEPTH) begin
        mem[wr_ptr] <= push_data;
        wr_ptr <= (wr_ptr + 1) % DEPTH;
      end
      if (fifo_rd_en) rd_ptr <= (rd_ptr + 1) % DEPTH;
      count <= count + ((push && count < DEPTH) ? 1 : 0) - (fifo_rd_en ? 1 : 0);
    end
  end

  assign fifo_nempty  = (count != 0);
  assign fifo_rd_data = mem[rd_ptr];

  int n_vec = 0;
  int n_err = 0;

  function automatic void check(string name, logic [OPW-1:0] got, logic [OPW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endfunction

  typedef struct {
    logic [N-1:0][W-1:0] w;
    int                  gap;
    logic [OPW-1:0]      exp_lsw;
    logic [OPW-1:0]      exp_msw;
  } vec_t;

  vec_t tbl [8];
  logic [OPW-1:0] sb [$];

  // Monitor: samples on the falling edge, inputs change just after the rising edge.
  int             cyc = 0;
  int             last_rise = -1;
  int             pops_mod = 0;
  int             total_pops = 0;
  logic           tput_on = 1'b0;
  logic           prev_valid = 1'b0, prev_ready = 1'b0, prev_rden = 1'b0;
  logic [OPW-1:0] prev_data = '0;
  logic [OPW-1:0] exp_op;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      prev_rden  = 1'b0;
      pops_mod   = 0;
      last_rise  = -1;
      sb.delete();
    end else begin
      if (prev_valid && !prev_ready) begin
        check("hold_valid", OPW'(out_valid), 1);
        check("hold_stable", out_data, prev_data);
      end
      if (out_valid) check("rd_en_in_hold", OPW'(fifo_rd_en), 0);
      if (fifo_rd_en) check("rd_en_needs_nempty", OPW'(fifo_nempty), 1);
      check("busy", OPW'(busy), OPW'((pops_mod != 0) || out_valid));
      if (out_valid && !prev_valid) begin
        check("valid_latency", OPW'(prev_rden), 1);
        check("spurious_valid", OPW'(sb.size() != 0), 1);
        if (tput_on && last_rise >= 0) check("throughput", OPW'(cyc - last_rise), N + 1);
        last_rise = cyc;
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        exp_op = sb.pop_front();
        check("operand", out_data, exp_op);
      end
      if (fifo_rd_en) begin
        pops_mod = (pops_mod + 1) % N;
        total_pops++;
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_data  = out_data;
      prev_rden  = fifo_rd_en;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [W-1:0] d);
    for (int i = 0; i < 50 && count >= DEPTH; i++) tick();
    if (count >= DEPTH) check("fifo_full_timeout", OPW'(count), DEPTH - 1);
    push      = 1'b1;
    push_data = d;
    tick();
    push      = 1'b0;
  endtask

  task automatic apply(input int idx);
`ifdef PACKER_MSW_FIRST_EN
    sb.push_back(tbl[idx].exp_msw);
`else
    sb.push_back(tbl[idx].exp_lsw);
`endif
    for (int k = 0; k < N; k++) begin
      push_word(tbl[idx].w[k]);
      repeat (tbl[idx].gap) tick();
    end
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 100 && !out_valid; i++) tick();
    check("valid_timeout", OPW'(out_valid), 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && (sb.size() != 0 || out_valid); i++) tick();
    check("drain_timeout", OPW'(sb.size() == 0 && !out_valid), 1);
  endtask

  task automatic set_vec(input int i, input logic [W-1:0] w0, w1, w2, w3,
                         input int gap, input logic [OPW-1:0] lsw, msw);
    tbl[i].w[0]    = w0;
    tbl[i].w[1]    = w1;
    tbl[i].w[2]    = w2;
    tbl[i].w[3]    = w3;
    tbl[i].gap     = gap;
    tbl[i].exp_lsw = lsw;
    tbl[i].exp_msw = msw;
  endtask

  int p0;

  initial begin
    set_vec(0, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 0, 64'h0004_0003_0002_0001, 64'h0001_0002_0003_0004);
    set_vec(1, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 3, 64'h0004_0003_0002_0001, 64'h0001_0002_0003_0004);
    set_vec(2, 16'h0011, 16'h0012, 16'h0013, 16'h0014, 0, 64'h0014_0013_0012_0011, 64'h0011_0012_0013_0014);
    set_vec(3, 16'h0015, 16'h0016, 16'h0017, 16'h0018, 0, 64'h0018_0017_0016_0015, 64'h0015_0016_0017_0018);
    set_vec(4, 16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4, 0, 64'h00A4_00A3_00A2_00A1, 64'h00A1_00A2_00A3_00A4);
    set_vec(5, 16'h1234, 16'hFFFF, 16'h0000, 16'hBEEF, 0, 64'hBEEF_0000_FFFF_1234, 64'h1234_FFFF_0000_BEEF);
    set_vec(6, 16'h8001, 16'h7FFE, 16'h0F0F, 16'hF0F0, 0, 64'hF0F0_0F0F_7FFE_8001, 64'h8001_7FFE_0F0F_F0F0);
    set_vec(7, 16'hAAAA, 16'h5555, 16'hC3C3, 16'h3C3C, 0, 64'h3C3C_C3C3_5555_AAAA, 64'hAAAA_5555_C3C3_3C3C);

    rst       = 1'b1;
    push      = 1'b0;
    push_data = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    check("reset_valid", OPW'(out_valid), 0);
    check("reset_busy", OPW'(busy), 0);
    check("reset_data", out_data, 0);
    check("reset_rd_en", OPW'(fifo_rd_en), 0);
    rst = 1'b0;
    tick();
    check("idle_rd_en", OPW'(fifo_rd_en), 0);

    // Back-to-back and gapped delivery of the same operand.
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      p0 = total_pops;
      apply(i);
      wait_drain();
      check("pop_count", OPW'(total_pops - p0), N);
    end

    // Downstream stalls for 10 cycles with two operands queued.
    out_ready = 1'b0;
    p0 = total_pops;
    apply(2);
    apply(3);
    wait_valid();
    repeat (10) tick();
    out_ready = 1'b1;
    wait_drain();
    check("pop_count_hold", OPW'(total_pops - p0), 2 * N);

    // Reset mid-collection discards the partial operand.
    push_word(16'h0BAD);
    push_word(16'h0BEE);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("valid_after_rst", OPW'(out_valid), 0);
    check("data_after_rst", out_data, 0);
    apply(4);
    wait_drain();

    // Reset while holding, with out_ready high in the same cycle.
    out_ready = 1'b0;
    apply(5);
    wait_valid();
    repeat (2) tick();
    rst       = 1'b1;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    check("hold_rst_valid", OPW'(out_valid), 0);
    check("hold_rst_busy", OPW'(busy), 0);
    tick();

    // Continuous stream of three operands.
    last_rise = -1;
    tput_on   = 1'b1;
    for (int i = 5; i < 8; i++) apply(i);
    wait_drain();
    tput_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
